// File: rtl/fu_mult_sched_pkg.sv
// Shared types for the multiply functional-unit scheduler: operand packet,
// CDB result and scheduler state encoding.
package fu_mult_sched_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned TAG_W  = 4;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] src_a;
        logic [DATA_W-1:0] src_b;
    } fu_pkt_t;

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } cdb_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } sched_state_t;

endpackage

// File: rtl/fu_mult_sched_if.sv
// Bundle of requester, multiplier and CDB signals around the scheduler.
// master = surrounding pipeline, slave = scheduler.
interface fu_mult_sched_if
    import fu_mult_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4
) ();

    logic                   flush;
    logic                   stall;
    logic [NUM_REQ-1:0]     req_valid;
    fu_pkt_t [NUM_REQ-1:0]  req_pkt;
    logic [NUM_REQ-1:0]     req_grant;
    logic                   mult_en;
    fu_pkt_t                mult_pkt;
    logic                   mult_busy;
    logic                   mult_resp_pulse;
    cdb_t                   mult_result;
    logic                   cdb_req;
    cdb_t                   cdb_out;
    logic                   cdb_ack;
    logic                   sched_busy;
    logic                   timeout_err;

    modport master (
        output flush, stall, req_valid, req_pkt, mult_busy,
               mult_resp_pulse, mult_result, cdb_ack,
        input  req_grant, mult_en, mult_pkt, cdb_req, cdb_out,
               sched_busy, timeout_err
    );

    modport slave (
        input  flush, stall, req_valid, req_pkt, mult_busy,
               mult_resp_pulse, mult_result, cdb_ack,
        output req_grant, mult_en, mult_pkt, cdb_req, cdb_out,
               sched_busy, timeout_err
    );

endinterface

// File: rtl/fu_mult_sched_rr_arbiter.sv
// Round-robin pick: first asserted request at or above ptr, wrapping modulo N.
module rr_arbiter #(
    parameter  int unsigned N  = 4,
    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [PW-1:0] o_idx,
    output logic          o_any
);

    logic [PW:0]   w_sum;
    logic [PW-1:0] w_cand;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_sum   = '0;
        w_cand  = '0;
        for (int unsigned off = 0; off < N; off++) begin
            w_sum = {1'b0, i_ptr} + (PW+1)'(off);
            if (w_sum >= (PW+1)'(N)) begin
                w_sum = w_sum - (PW+1)'(N);
            end
            w_cand = PW'(w_sum);
            if (!o_any && i_req[w_cand]) begin
                o_any           = 1'b1;
                o_grant[w_cand] = 1'b1;
                o_idx           = w_cand;
            end
        end
    end

endmodule

// File: rtl/fu_mult_sched.sv
// Issues one multiply at a time from NUM_REQ requesters, waits for the
// sequential multiplier and holds the result on the CDB until acknowledged.
module fu_mult_sched
    import fu_mult_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned WAIT_LIMIT = 16
) (
    input  logic            clk,
    input  logic            rst,
    fu_mult_sched_if.slave  bus
);

    localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CW = $clog2(WAIT_LIMIT + 1);

    sched_state_t       r_state;
    sched_state_t       w_next;
    logic [PW-1:0]      r_rr_ptr;
    logic [PW-1:0]      w_ptr_nxt;
    logic [PW-1:0]      w_idx;
    logic [NUM_REQ-1:0] w_gnt;
    logic               w_any;
    logic               w_issue;
    logic               w_capture;
    logic               w_cdb_req;
    logic [CW-1:0]      r_wait_cnt;
    logic [CW-1:0]      w_wait_inc;
    logic               r_timeout;
    logic [TAG_W-1:0]   r_buf_tag;
    logic [DATA_W-1:0]  r_buf_data;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .i_req   (bus.req_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_gnt),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Flush overrides every state; issue and CDB request are combinational.
    always_comb begin
        w_next    = r_state;
        w_issue   = 1'b0;
        w_capture = 1'b0;
        w_cdb_req = 1'b0;
        if (bus.flush) begin
            w_next = IDLE;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_any && !bus.stall && !bus.mult_busy && !rst) begin
                        w_issue = 1'b1;
                        w_next  = WAIT;
                    end
                end
                WAIT: begin
                    if (bus.mult_resp_pulse) begin
                        w_capture = 1'b1;
                        w_next    = RESP;
                    end
                end
                RESP: begin
                    w_cdb_req = 1'b1;
                    if (bus.cdb_ack) begin
                        w_next = IDLE;
                    end
                end
                default: w_next = IDLE;
            endcase
        end
    end

    assign w_ptr_nxt  = (w_idx == PW'(NUM_REQ - 1)) ? '0 : w_idx + PW'(1);
    assign w_wait_inc = r_wait_cnt + CW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr   <= '0;
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
            r_buf_tag  <= '0;
            r_buf_data <= '0;
        end else begin
            if (w_issue) begin
                r_rr_ptr   <= w_ptr_nxt;
                r_wait_cnt <= '0;
            end else if (r_state == WAIT && r_wait_cnt != CW'(WAIT_LIMIT)) begin
                r_wait_cnt <= w_wait_inc;
                if (w_wait_inc == CW'(WAIT_LIMIT)) begin
                    r_timeout <= 1'b1;
                end
            end
            if (bus.flush || (r_state == RESP && bus.cdb_ack)) begin
                r_buf_tag  <= '0;
                r_buf_data <= '0;
            end else if (w_capture) begin
                r_buf_tag  <= bus.mult_result.tag;
                r_buf_data <= bus.mult_result.data;
            end
        end
    end

    assign bus.req_grant   = w_issue ? w_gnt : '0;
    assign bus.mult_en     = w_issue;
    assign bus.mult_pkt    = w_issue ? bus.req_pkt[w_idx] : '0;
    assign bus.cdb_req     = w_cdb_req;
    assign bus.cdb_out     = w_cdb_req ? cdb_t'{valid: 1'b1, tag: r_buf_tag, data: r_buf_data} : '0;
    assign bus.sched_busy  = (r_state != IDLE);
    assign bus.timeout_err = r_timeout;

endmodule

// File: tb/tb_fu_mult_sched.sv
// Directed bench for fu_mult_sched with a behavioural multiplier and a
// scoreboard of expected CDB results.
module tb_fu_mult_sched;
    import fu_mult_sched_pkg::*;

    logic clk = 1'b0;
    logic rst;

    int n_checks = 0;
    int n_fail   = 0;

    fu_pkt_t pkts [4];
    cdb_t    sb   [$];

    fu_mult_sched_if #(.NUM_REQ(4)) bus ();

    fu_mult_sched #(.NUM_REQ(4), .WAIT_LIMIT(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic cdb_t exp_result(input fu_pkt_t p);
        cdb_t c;
        c.valid = 1'b1;
        c.tag   = p.tag;
        c.data  = DATA_W'(p.src_a * p.src_b);
        return c;
    endfunction

    function automatic int onehot_idx(input logic [3:0] g);
        int r = 0;
        for (int i = 0; i < 4; i++) if (g[i]) r = i;
        return r;
    endfunction

    // Issue (inputs already driven), run multiplier for lat cycles, hold ack off ack_wait cycles.
    task automatic run_op(input logic [3:0] exp_g, input int lat, input int ack_wait);
        int      idx;
        fu_pkt_t cap;
        cdb_t    exp_c;
        idx = onehot_idx(exp_g);
        #1;
        chk("grant", 128'(bus.req_grant), 128'(exp_g));
        chk("mult_en", 128'(bus.mult_en), 128'(1'b1));
        chk("mult_pkt", 128'(bus.mult_pkt), 128'(pkts[idx]));
        cap = bus.mult_pkt;
        sb.push_back(exp_result(pkts[idx]));
        @(negedge clk);
        bus.mult_busy = 1'b1;
        #1;
        chk("wait_no_issue", 128'({bus.req_grant, bus.mult_en}), 128'(0));
        chk("busy_in_wait", 128'(bus.sched_busy), 128'(1'b1));
        repeat (lat - 1) @(negedge clk);
        bus.mult_resp_pulse = 1'b1;
        bus.mult_result     = '{valid: 1'b1, tag: cap.tag, data: DATA_W'(cap.src_a * cap.src_b)};
        @(negedge clk);
        bus.mult_resp_pulse = 1'b0;
        bus.mult_result     = '0;
        bus.mult_busy       = 1'b0;
        #1;
        chk("cdb_req", 128'(bus.cdb_req), 128'(1'b1));
        chk("sb_nonempty", 128'(sb.size() > 0), 128'(1'b1));
        exp_c = (sb.size() > 0) ? sb.pop_front() : cdb_t'('0);
        chk("cdb_out", 128'(bus.cdb_out), 128'(exp_c));
        for (int k = 0; k < ack_wait; k++) begin
            @(negedge clk);
            #1;
            chk("cdb_hold", 128'({bus.cdb_req, bus.cdb_out}), 128'({1'b1, exp_c}));
        end
        bus.cdb_ack = 1'b1;
        #1;
        chk("ack_no_issue", 128'(bus.req_grant), 128'(0));
        @(negedge clk);
        bus.cdb_ack = 1'b0;
        #1;
        chk("post_ack_idle", 128'({bus.cdb_req, bus.sched_busy}), 128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4; i++) begin
            pkts[i].tag   = TAG_W'(i + 1);
            pkts[i].src_a = DATA_W'(i + 2);
            pkts[i].src_b = DATA_W'(3);
        end
        rst                 = 1'b1;
        bus.flush           = 1'b0;
        bus.stall           = 1'b0;
        bus.req_valid       = 4'b0001;
        bus.req_pkt         = {pkts[3], pkts[2], pkts[1], pkts[0]};
        bus.mult_busy       = 1'b0;
        bus.mult_resp_pulse = 1'b0;
        bus.mult_result     = '0;
        bus.cdb_ack         = 1'b0;

        // Reset values with a request pending.
        @(negedge clk);
        #1;
        chk("rst_grant", 128'({bus.req_grant, bus.mult_en}), 128'(0));
        chk("rst_pkt", 128'(bus.mult_pkt), 128'(0));
        chk("rst_cdb", 128'({bus.cdb_req, bus.cdb_out}), 128'(0));
        chk("rst_flags", 128'({bus.sched_busy, bus.timeout_err}), 128'(0));

        // Single op, data 6, ack withheld 3 cycles.
        @(negedge clk);
        rst = 1'b0;
        run_op(4'b0001, 3, 3);
        bus.req_valid = 4'b1111;
        #1;
        chk("rr_ptr_after0", 128'(bus.req_grant), 128'(4'b0010));

        // Fresh reset, all requesters valid: 0,1,2,3,0.
        rst = 1'b1;
        #1;
        chk("rst_async_grant", 128'(bus.req_grant), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        run_op(4'b0001, 2, 0);
        run_op(4'b0010, 1, 1);
        run_op(4'b0100, 4, 0);
        run_op(4'b1000, 2, 2);
        run_op(4'b0001, 1, 0);
        bus.req_valid = 4'b0000;

        // Stall blocks issue, release grants requester 2.
        @(negedge clk);
        bus.req_valid = 4'b0100;
        bus.stall     = 1'b1;
        #1;
        chk("stall_no_grant", 128'({bus.req_grant, bus.mult_en}), 128'(0));
        @(negedge clk);
        #1;
        chk("stall_idle", 128'({bus.req_grant, bus.sched_busy}), 128'(0));
        bus.stall = 1'b0;
        #1;
        chk("unstall_grant", 128'(bus.req_grant), 128'(4'b0100));
        sb.push_back(exp_result(pkts[2]));

        // Flush coincident with the multiplier response discards it.
        @(negedge clk);
        bus.req_valid       = 4'b0000;
        bus.mult_busy       = 1'b1;
        bus.flush           = 1'b1;
        bus.mult_resp_pulse = 1'b1;
        bus.mult_result     = '{valid: 1'b1, tag: 4'h3, data: 32'd12};
        #1;
        chk("flush_cycle", 128'({bus.cdb_req, bus.mult_en}), 128'(0));
        @(negedge clk);
        bus.flush           = 1'b0;
        bus.mult_resp_pulse = 1'b0;
        bus.mult_busy       = 1'b0;
        #1;
        chk("flush_dropped", 128'({bus.cdb_req, bus.sched_busy, bus.cdb_out}), 128'(0));
        if (sb.size() > 0) void'(sb.pop_back());

        // Pointer kept across flush: next winner is requester 3.
        bus.req_valid = 4'b1111;
        #1;
        chk("rr_ptr_kept", 128'(bus.req_grant), 128'(4'b1000));

        // No response: timeout after 16 WAIT cycles, sticky through flush.
        @(negedge clk);
        bus.req_valid = 4'b0000;
        bus.mult_busy = 1'b1;
        repeat (15) @(negedge clk);
        #1;
        chk("timeout_pre", 128'(bus.timeout_err), 128'(1'b0));
        @(negedge clk);
        #1;
        chk("timeout_set", 128'({bus.timeout_err, bus.sched_busy}), 128'(2'b11));
        @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush     = 1'b0;
        bus.mult_busy = 1'b0;
        #1;
        chk("timeout_sticky", 128'({bus.timeout_err, bus.sched_busy}), 128'(2'b10));

        // Stray response in IDLE is ignored.
        bus.mult_resp_pulse = 1'b1;
        bus.mult_result     = '{valid: 1'b1, tag: 4'h9, data: 32'hdead};
        @(negedge clk);
        bus.mult_resp_pulse = 1'b0;
        #1;
        chk("stray_resp", 128'({bus.cdb_req, bus.sched_busy}), 128'(0));

        rst = 1'b1;
        #1;
        chk("timeout_rst", 128'(bus.timeout_err), 128'(1'b0));
        @(negedge clk);
        rst = 1'b0;
        chk("sb_empty", 128'(sb.size()), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fu_mult_sched.md
FU_MULT_SCHED -- requirements
Module: fu_mult_sched

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of multiply requesters (reservation-station slots).
REQ-002 SHALL have parameter WAIT_LIMIT, default 16: maximum WAIT cycles before timeout.
REQ-003 SHALL have one clock; reset is asynchronous and active-high (ports clk, rst).
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  async active-high reset.
REQ-006 flush  input  1  pipeline flush, synchronous.
REQ-007 stall  input  1  pipeline stall; blocks new issue.
REQ-008 req_valid  input  NUM_REQ  requester i holds a ready multiply op.
REQ-009 req_pkt  input  NUM_REQ x fu_pkt_t  per-requester operand packet.
REQ-010 req_grant  output  NUM_REQ  one-hot, 1-cycle pulse: requester i accepted; requester drops its entry.
REQ-011 mult_en  output  1  1-cycle start pulse to the sequential multiplier.
REQ-012 mult_pkt  output  fu_pkt_t  packet presented with mult_en.
REQ-013 mult_busy  input  1  multiplier busy.
REQ-014 mult_resp_pulse  input  1  multiplier result valid, 1 cycle.
REQ-015 mult_result  input  cdb_t  multiplier result, sampled on mult_resp_pulse.
REQ-016 cdb_req  output  1  buffered result requests CDB.
REQ-017 cdb_out  output  cdb_t  buffered result; valid field equals cdb_req.
REQ-018 cdb_ack  input  1  CDB accepted cdb_out this cycle.
REQ-019 sched_busy  output  1  state is not IDLE.
REQ-020 timeout_err  output  1  sticky: WAIT exceeded WAIT_LIMIT.

Function
REQ-021 SHALL implement FSM with states IDLE, WAIT, RESP.
REQ-022 IDLE: if any req_valid, !stall, !flush, !mult_busy -> same cycle assert req_grant[w], mult_en=1, mult_pkt=req_pkt[w] (combinational); next state WAIT.
REQ-023 Winner w SHALL be the first valid index at or after rr_ptr, searching upward modulo NUM_REQ.
REQ-024 On grant to w, rr_ptr SHALL become (w+1) mod NUM_REQ; it is otherwise unchanged.
REQ-025 Outside an IDLE issue cycle, req_grant SHALL be 0 and mult_en SHALL be 0; mult_pkt SHALL be '0.
REQ-026 WAIT: on mult_resp_pulse && !flush, capture mult_result into result buffer; next state RESP.
REQ-027 WAIT: wait counter SHALL increment per cycle (stall does not freeze it), saturating; when it reaches WAIT_LIMIT, timeout_err SHALL set; FSM stays in WAIT.
REQ-028 Wait counter SHALL clear on entry to WAIT.
REQ-029 RESP: cdb_req=1, cdb_out=buffer with valid=1; held stable until cdb_ack; cdb_ack -> IDLE; no issue in the ack cycle.
REQ-030 stall SHALL NOT drop cdb_req or alter the buffer in RESP.
REQ-031 mult_resp_pulse outside WAIT SHALL be ignored.
REQ-032 flush in any state: next state IDLE, buffer cleared, cdb_req=0 and mult_en=0 that cycle, rr_ptr retained, timeout_err retained.
REQ-033 flush coincident with mult_resp_pulse: result discarded.
REQ-034 flush coincident with cdb_ack in RESP: treated as flush; next state IDLE.
REQ-035 Throughput SHALL be at most one op in flight; issue-to-next-issue ≥ multiplier latency + 2 cycles.

Reset
REQ-036 rst SHALL asynchronously force state IDLE, rr_ptr=0, wait counter=0, buffer='0, timeout_err=0.
REQ-037 During and after reset: req_grant=0, mult_en=0, mult_pkt='0, cdb_req=0, cdb_out='0, sched_busy=0.
REQ-038 Reset mid-WAIT SHALL abandon the op; a later mult_resp_pulse SHALL be ignored.

Structure
REQ-039 fu_pkt_t and cdb_t SHALL come from the shared types package; the state enum (IDLE/WAIT/RESP) SHALL be declared in that package.
REQ-040 Round-robin selection SHALL be a sub-module rr_arbiter (inputs req, ptr; output one-hot grant).

Verification
REQ-041 Reset, then req_valid=4'b0001, mult_busy=0 -> req_grant=0001 and mult_en the same cycle; rr_ptr=1.
REQ-042 req_valid=4'b1111 held, rr_ptr=0, four complete ops -> grants in order 0,1,2,3, then 0.
REQ-043 Op in WAIT, mult_resp_pulse with data=0x0000_0006 -> next cycle cdb_req=1, cdb_out.data=0x6; cdb_ack withheld 3 cycles -> cdb_out stable; ack -> IDLE.
REQ-044 flush in the same cycle as mult_resp_pulse -> cdb_req stays 0; state IDLE; rr_ptr unchanged.
REQ-045 stall=1 in IDLE with req_valid=4'b0100 -> no grant; stall drops -> grant=0100.
REQ-046 WAIT with no mult_resp_pulse for 16 cycles -> timeout_err=1, sticky through flush, cleared by rst.
